// File: rtl/ex_stage_mdu.sv
// Execute stage: single-cycle ALU/MF path into an EX/MEM slot, plus a background MULT/DIV unit owning HI/LO.
// Latency: ALU/MF 1 cycle; MULT/MULTU MUL_LAT cycles; DIV/DIVU DW+1 cycles (1 cycle on divide-by-zero).
// Backpressure: slot holds while out_ready_87=0; in_ready_87 drops for a full slot, flush, or an MDU/HI-LO consumer while busy.
module ex_stage_mdu #(
  parameter int DW      = 32,
  parameter int AW      = 32,
  parameter int RW      = 5,
  parameter int MUL_LAT = 4
) (
  input  logic          clk_87,
  input  logic          rst_87,
  input  logic          flush_87,
  input  logic          in_valid_87,
  output logic          in_ready_87,
  input  logic [3:0]    op_87,
  input  logic          alu_src_87,
  input  logic [DW-1:0] rval_a_87,
  input  logic [DW-1:0] rval_b_87,
  input  logic [DW-1:0] imm_87,
  input  logic [4:0]    shamt_87,
  input  logic [AW-1:0] pc_in_87,
  input  logic [RW-1:0] wreg_in_87,
  output logic          out_valid_87,
  input  logic          out_ready_87,
  output logic [DW-1:0] result_87,
  output logic          zero_87,
  output logic [AW-1:0] pc_brnch_87,
  output logic [AW-1:0] pc_out_87,
  output logic [RW-1:0] wreg_out_87,
  output logic          mdu_busy_87
);

  localparam logic [3:0] OP_ADD   = 4'd0;
  localparam logic [3:0] OP_SUB   = 4'd1;
  localparam logic [3:0] OP_AND   = 4'd2;
  localparam logic [3:0] OP_OR    = 4'd3;
  localparam logic [3:0] OP_SLT   = 4'd4;
  localparam logic [3:0] OP_SLTU  = 4'd5;
  localparam logic [3:0] OP_SLL   = 4'd6;
  localparam logic [3:0] OP_SRL   = 4'd7;
  localparam logic [3:0] OP_MULT  = 4'd8;
  localparam logic [3:0] OP_MULTU = 4'd9;
  localparam logic [3:0] OP_DIV   = 4'd10;
  localparam logic [3:0] OP_DIVU  = 4'd11;
  localparam logic [3:0] OP_MFHI  = 4'd12;
  localparam logic [3:0] OP_MFLO  = 4'd13;

  // Counter must hold both the multiply delay and the divide bit count.
  localparam int CMAX = (DW > MUL_LAT) ? DW : MUL_LAT;
  localparam int CW   = $clog2(CMAX + 1);

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV} mdu_state_t;

  mdu_state_t          r_state;
  logic [CW-1:0]       r_cnt;
  logic [DW-1:0]       r_hi, r_lo;
  logic [2*DW-1:0]     r_prod;
  logic [DW-1:0]       r_quo, r_rem, r_dvs, r_dividend;
  logic                r_dvz, r_neg_q, r_neg_r;

  logic                r_out_valid, r_zero;
  logic [DW-1:0]       r_result;
  logic [AW-1:0]       r_pc_brnch, r_pc_out;
  logic [RW-1:0]       r_wreg;

  logic [DW-1:0]       w_opb, w_alu_res;
  logic [31:0]         w_sh;
  logic                w_is_mdu, w_is_mf, w_hazard, w_accept;
  logic                w_mul_signed, w_div_signed, w_sa, w_sb;
  logic [2*DW-1:0]     w_mul_a, w_mul_b, w_prod;
  logic [DW-1:0]       w_mag_a, w_mag_b, w_q_fin, w_r_fin;
  logic [DW:0]         w_rem_sh, w_diff;
  logic [AW-1:0]       w_imm_aw, w_brnch;

  assign w_opb        = alu_src_87 ? imm_87 : rval_b_87;
  assign w_sh         = {27'd0, shamt_87} % 32'(DW);
  assign w_is_mdu     = (op_87 >= OP_MULT) && (op_87 <= OP_DIVU);
  assign w_is_mf      = (op_87 == OP_MFHI) || (op_87 == OP_MFLO);
  assign mdu_busy_87  = (r_state != S_IDLE);
  assign w_hazard     = mdu_busy_87 & (w_is_mdu | w_is_mf);
  assign in_ready_87  = (!r_out_valid | out_ready_87) & !w_hazard & !flush_87;
  assign w_accept     = in_valid_87 & in_ready_87;

  // Multiply: extend both operands to 2DW so the truncated product is exact for either signedness.
  assign w_mul_signed = (op_87 == OP_MULT);
  assign w_mul_a      = w_mul_signed ? {{DW{rval_a_87[DW-1]}}, rval_a_87} : {{DW{1'b0}}, rval_a_87};
  assign w_mul_b      = w_mul_signed ? {{DW{w_opb[DW-1]}}, w_opb} : {{DW{1'b0}}, w_opb};
  assign w_prod       = w_mul_a * w_mul_b;

  // Divide works on magnitudes; signs are reapplied when the result is written.
  assign w_div_signed = (op_87 == OP_DIV);
  assign w_sa         = w_div_signed & rval_a_87[DW-1];
  assign w_sb         = w_div_signed & w_opb[DW-1];
  assign w_mag_a      = w_sa ? -rval_a_87 : rval_a_87;
  assign w_mag_b      = w_sb ? -w_opb : w_opb;
  assign w_rem_sh     = {r_rem, r_quo[DW-1]};
  assign w_diff       = w_rem_sh - {1'b0, r_dvs};
  assign w_q_fin      = r_neg_q ? -r_quo : r_quo;
  assign w_r_fin      = r_neg_r ? -r_rem : r_rem;

  generate
    if (AW <= DW) begin : g_imm_trunc
      assign w_imm_aw = imm_87[AW-1:0];
    end else begin : g_imm_sext
      assign w_imm_aw = {{(AW-DW){imm_87[DW-1]}}, imm_87};
    end
  endgenerate
  assign w_brnch = pc_in_87 + {w_imm_aw[AW-3:0], 2'b00};

  // Single-cycle ALU and HI/LO read mux.
  always_comb begin
    w_alu_res = '0;
    case (op_87)
      OP_ADD:  w_alu_res = rval_a_87 + w_opb;
      OP_SUB:  w_alu_res = rval_a_87 - w_opb;
      OP_AND:  w_alu_res = rval_a_87 & w_opb;
      OP_OR:   w_alu_res = rval_a_87 | w_opb;
      OP_SLT:  w_alu_res = {{(DW-1){1'b0}}, ($signed(rval_a_87) < $signed(w_opb))};
      OP_SLTU: w_alu_res = {{(DW-1){1'b0}}, (rval_a_87 < w_opb)};
      OP_SLL:  w_alu_res = rval_b_87 << w_sh;
      OP_SRL:  w_alu_res = rval_b_87 >> w_sh;
      OP_MFHI: w_alu_res = r_hi;
      OP_MFLO: w_alu_res = r_lo;
      default: w_alu_res = rval_a_87 + w_opb;
    endcase
  end

  // EX/MEM output slot: load on ALU/MF accept, drain when MEM takes it, kill on flush.
  always_ff @(posedge clk_87 or posedge rst_87) begin
    if (rst_87) begin
      r_out_valid <= 1'b0;
      r_result    <= '0;
      r_zero      <= 1'b0;
      r_pc_brnch  <= '0;
      r_pc_out    <= '0;
      r_wreg      <= '0;
    end else if (flush_87) begin
      r_out_valid <= 1'b0;
    end else if (w_accept && !w_is_mdu) begin
      r_out_valid <= 1'b1;
      r_result    <= w_alu_res;
      r_zero      <= (w_alu_res == '0);
      r_pc_brnch  <= w_brnch;
      r_pc_out    <= pc_in_87;
      r_wreg      <= wreg_in_87;
    end else if (out_ready_87) begin
      r_out_valid <= 1'b0;
    end
  end

  // MDU FSM: counts down the multiply delay or steps the restoring divider, then commits HI/LO.
  always_ff @(posedge clk_87 or posedge rst_87) begin
    if (rst_87) begin
      r_state    <= S_IDLE;
      r_cnt      <= '0;
      r_hi       <= '0;
      r_lo       <= '0;
      r_prod     <= '0;
      r_quo      <= '0;
      r_rem      <= '0;
      r_dvs      <= '0;
      r_dividend <= '0;
      r_dvz      <= 1'b0;
      r_neg_q    <= 1'b0;
      r_neg_r    <= 1'b0;
    end else if (flush_87) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept && w_is_mdu) begin
            if ((op_87 == OP_MULT) || (op_87 == OP_MULTU)) begin
              r_state <= S_MUL;
              r_cnt   <= CW'(MUL_LAT - 1);
              r_prod  <= w_prod;
            end else begin
              r_state    <= S_DIV;
              r_dvz      <= (w_opb == '0);
              r_cnt      <= (w_opb == '0) ? '0 : CW'(DW);
              r_quo      <= w_mag_a;
              r_dvs      <= w_mag_b;
              r_rem      <= '0;
              r_dividend <= rval_a_87;
              r_neg_q    <= w_sa ^ w_sb;
              r_neg_r    <= w_sa;
            end
          end
        end
        S_MUL: begin
          if (r_cnt == '0) begin
            r_hi    <= r_prod[2*DW-1:DW];
            r_lo    <= r_prod[DW-1:0];
            r_state <= S_IDLE;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        S_DIV: begin
          if (r_cnt == '0) begin
            if (r_dvz) begin
              r_lo <= '1;
              r_hi <= r_dividend;
            end else begin
              r_lo <= w_q_fin;
              r_hi <= w_r_fin;
            end
            r_state <= S_IDLE;
          end else begin
            if (!w_diff[DW]) begin
              r_rem <= w_diff[DW-1:0];
              r_quo <= {r_quo[DW-2:0], 1'b1};
            end else begin
              r_rem <= w_rem_sh[DW-1:0];
              r_quo <= {r_quo[DW-2:0], 1'b0};
            end
            r_cnt <= r_cnt - 1'b1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign out_valid_87 = r_out_valid;
  assign result_87    = r_result;
  assign zero_87      = r_zero;
  assign pc_brnch_87  = r_pc_brnch;
  assign pc_out_87    = r_pc_out;
  assign wreg_out_87  = r_wreg;

endmodule
